// File: rtl/snap_capture_ram_if.sv
// snap_capture_ram_if: capture stream, status and 32-bit cpu read bus for snap_capture_ram; master drives arm/post_len/trig/din_valid/din/cpu_en/cpu_addr, slave returns busy/done/wr_count/trig_addr/start_addr/cpu_rdata/cpu_rvalid
interface snap_capture_ram_if #(parameter int DWIDTH = 128, parameter int AWIDTH = 10);
  localparam int LB = $clog2(DWIDTH / 32);
  logic arm;
  logic [AWIDTH:0] post_len;
  logic trig;
  logic din_valid;
  logic [DWIDTH-1:0] din;
  logic busy;
  logic done;
  logic [AWIDTH:0] wr_count;
  logic [AWIDTH-1:0] trig_addr;
  logic [AWIDTH-1:0] start_addr;
  logic cpu_en;
  logic [AWIDTH+LB-1:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic cpu_rvalid;
  modport master (
    output arm, post_len, trig, din_valid, din, cpu_en, cpu_addr,
    input busy, done, wr_count, trig_addr, start_addr, cpu_rdata, cpu_rvalid
  );
  modport slave (
    input arm, post_len, trig, din_valid, din, cpu_en, cpu_addr,
    output busy, done, wr_count, trig_addr, start_addr, cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/snap_capture_ram.sv
// snap_capture_ram: arm/trigger snapshot RAM with optional pre-trigger ring (SNAP_CIRCULAR_EN) and 2-cycle 32-bit cpu read port; ports clk, rst (sync, active-high), bus (snap_capture_ram_if.slave)
module snap_capture_ram #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 10
) (
  input logic clk,
  input logic rst,
  snap_capture_ram_if.slave bus
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int LANES = DWIDTH / 32;
  localparam int LB = $clog2(LANES);
  localparam int LBW = LB > 0 ? LB : 1;
  localparam logic [AWIDTH:0] FULL = (AWIDTH + 1)'(DEPTH);
`ifdef SNAP_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, wp_n, rd_sa;
  logic [AWIDTH:0] plen, pcnt, pn, wc_n, plen_d;
  logic [LBW-1:0] lane_d, lane_q;
  logic [DWIDTH-1:0] rd_q;
  logic we, hit, post, rd_v;
  always_comb begin
    hit = state == ARMED && bus.trig && bus.din_valid;
    post = state == CAPTURE || hit;
    we = !bus.arm && bus.din_valid && (state == CAPTURE || (state == ARMED && (bus.trig || CIRC)));
    wp_n = wr_ptr + 1'b1;
    wc_n = bus.wr_count == FULL ? bus.wr_count : bus.wr_count + 1'b1;
    pn = pcnt + 1'b1;
    plen_d = (bus.post_len == '0 || bus.post_len > FULL) ? FULL : bus.post_len;
    rd_sa = bus.cpu_addr[AWIDTH+LB-1 -: AWIDTH];
    lane_d = LBW'(bus.cpu_addr) & LBW'(LANES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      wr_ptr <= '0;
      bus.wr_count <= '0;
      bus.trig_addr <= '0;
      bus.start_addr <= '0;
      plen <= '0;
      pcnt <= '0;
    end else if (bus.arm) begin
      state <= ARMED;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
      wr_ptr <= '0;
      bus.wr_count <= '0;
      bus.trig_addr <= '0;
      bus.start_addr <= '0;
      plen <= plen_d;
      pcnt <= '0;
    end else if (we) begin
      wr_ptr <= wp_n;
      bus.wr_count <= wc_n;
      bus.start_addr <= wp_n - wc_n[AWIDTH-1:0];
      if (hit) bus.trig_addr <= wr_ptr;
      if (post) pcnt <= pn;
      if (post && pn == plen) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end else if (hit) state <= CAPTURE;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= bus.din;
    rd_q <= mem[rd_sa];
    lane_q <= lane_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      rd_v <= bus.cpu_en;
      bus.cpu_rvalid <= rd_v;
      if (rd_v) bus.cpu_rdata <= rd_q[{lane_q, 5'd0} +: 32];
    end
  end
endmodule

// File: tb/tb_snap_capture_ram.sv
// tb_snap_capture_ram: directed and random checks of snap_capture_ram against a sample-count reference model
module tb_snap_capture_ram;
  localparam int DW = 128;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef SNAP_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  localparam logic [127:0] PAT = 128'h01234567_DEADBEEF_76543210_89ABCDEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  snap_capture_ram_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
  snap_capture_ram #(.DWIDTH(DW), .AWIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int ms = 0, n_wr = 0, ta = 0, plen = 16, posts = 0, rv_cnt = 0, base = 0;
  logic [127:0] mm [DEPTH];
  bit mk [DEPTH];
  bit p1v = 0, p2v = 0, p1k = 0, p2k = 0;
  logic [31:0] p1d = '0, p2d = '0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] smp(input int i);
    return {$urandom, $urandom, $urandom, 32'(i)};
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic step(input logic r, input logic a, input logic t, input logic v,
                      input logic [127:0] d, input logic [4:0] pl, input logic ce, input logic [5:0] ca);
    logic [127:0] tmp;
    int sa;
    rst = r; bus.arm = a; bus.trig = t; bus.din_valid = v; bus.din = d;
    bus.post_len = pl; bus.cpu_en = ce; bus.cpu_addr = ca;
    @(posedge clk);
    sa = int'(ca[5:2]);
    tmp = mm[sa] >> (32 * int'(ca[1:0]));
    p2v = p1v; p2k = p1k; p2d = p1d;
    p1v = ce; p1k = mk[sa]; p1d = tmp[31:0];
    if (r) begin
      ms = 0; n_wr = 0; ta = 0; posts = 0; p1v = 0; p2v = 0;
    end else if (a) begin
      ms = 1; n_wr = 0; ta = 0; posts = 0;
      plen = (pl == 0 || pl > DEPTH) ? DEPTH : int'(pl);
    end else if (v && (ms == 2 || (ms == 1 && (t || CIRC)))) begin
      mm[n_wr % DEPTH] = d;
      mk[n_wr % DEPTH] = 1;
      if (ms == 1 && t) begin
        ta = n_wr % DEPTH; posts = 1; ms = (plen == 1) ? 3 : 2;
      end else if (ms == 2) begin
        posts++;
        if (posts == plen) ms = 3;
      end
      n_wr++;
    end
    #1;
    chk("busy", bus.busy, ms == 1 || ms == 2);
    chk("done", bus.done, ms == 3);
    chk("wr_count", bus.wr_count, n_wr < DEPTH ? n_wr : DEPTH);
    chk("trig_addr", bus.trig_addr, ta);
    chk("start_addr", bus.start_addr, n_wr >= DEPTH ? n_wr % DEPTH : 0);
    chk("cpu_rvalid", bus.cpu_rvalid, p2v);
    if (p2v && p2k) chk("cpu_rdata", bus.cpu_rdata, p2d);
    if (bus.cpu_rvalid) rv_cnt++;
  endtask
  task automatic s(input logic t, input logic [127:0] d);
    step(0, 0, t, 1, d, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, rnd(), 0, 0, 0);
  endtask
  task automatic do_arm(input logic [4:0] pl);
    step(0, 1, 0, 0, rnd(), pl, 0, 0);
  endtask
  task automatic rd(input logic [5:0] ca);
    step(0, 0, 0, 0, rnd(), 0, 1, ca);
  endtask
  task automatic rd_chk(input string tag, input logic [5:0] ca, input logic [31:0] exp);
    rd(ca);
    chk({tag, "_lat1"}, bus.cpu_rvalid, 0);
    idle();
    chk({tag, "_rvalid"}, bus.cpu_rvalid, 1);
    chk(tag, bus.cpu_rdata, exp);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = 0; end
    step(1, 0, 0, 0, '0, 0, 0, 0);
    step(1, 0, 1, 1, rnd(), 0, 1, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_busy", bus.busy, 0);
    idle();
    idle();
    do_arm(5);
    for (int i = 0; i < 7; i++) s(0, smp(i));
    s(1, smp(7));
    for (int i = 8; i < 11; i++) s(0, smp(i));
    chk("A_not_done", bus.done, 0);
    s(0, smp(11));
    chk("A_done", bus.done, 1);
`ifdef SNAP_CIRCULAR_EN
    chk("A_cnt", bus.wr_count, 12);
    chk("A_taddr", bus.trig_addr, 7);
    base = 0;
`else
    chk("A_cnt", bus.wr_count, 5);
    chk("A_taddr", bus.trig_addr, 0);
    base = 7;
`endif
    s(0, smp(99));
    chk("A_hold", bus.done, 1);
    for (int i = 0; i < 5; i++) rd_chk("A_ram", {4'(i), 2'd0}, 32'(base + i));
    do_arm(4);
    for (int i = 0; i < 20; i++) s(0, smp(i));
    s(1, smp(20));
    for (int i = 21; i < 24; i++) s(0, smp(i));
    chk("B_done", bus.done, 1);
`ifdef SNAP_CIRCULAR_EN
    chk("B_taddr", bus.trig_addr, 4);
    chk("B_cnt", bus.wr_count, 16);
    chk("B_start", bus.start_addr, 8);
    for (int i = 0; i < 16; i++) rd_chk("B_ram", {4'((8 + i) % 16), 2'd0}, 32'(8 + i));
`else
    chk("B_taddr", bus.trig_addr, 0);
    chk("B_cnt", bus.wr_count, 4);
    chk("B_start", bus.start_addr, 0);
    for (int i = 0; i < 4; i++) rd_chk("B_ram", {4'(i), 2'd0}, 32'(20 + i));
`endif
    do_arm(4);
    s(1, rnd());
    s(0, rnd());
    s(0, rnd());
    s(0, PAT);
    chk("C_done", bus.done, 1);
    rd_chk("C_lane2", {4'd3, 2'd2}, 32'hDEADBEEF);
    idle();
    chk("C_pulse", bus.cpu_rvalid, 0);
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) rd({4'd3, 2'(i)});
    for (int i = 0; i < 3; i++) idle();
    chk("C_b2b", rv_cnt, 4);
    do_arm(6);
    s(1, rnd());
    s(0, rnd());
    do_arm(6);
    chk("D_busy", bus.busy, 1);
    chk("D_done", bus.done, 0);
    chk("D_cnt", bus.wr_count, 0);
    s(1, rnd());
    for (int i = 0; i < 5; i++) s(0, rnd());
    chk("D_done2", bus.done, 1);
    chk("D_cnt2", bus.wr_count, 6);
    do_arm(0);
    s(1, rnd());
    for (int i = 0; i < 14; i++) s(0, rnd());
    chk("E_not_done", bus.done, 0);
    s(0, rnd());
    chk("E_done", bus.done, 1);
    chk("E_cnt", bus.wr_count, 16);
    step(0, 1, 1, 1, rnd(), 2, 0, 0);
    chk("F_busy", bus.busy, 1);
    chk("F_cnt", bus.wr_count, 0);
    s(0, rnd());
    chk("F_no_trig", bus.done, 0);
    s(1, rnd());
    s(0, rnd());
    chk("F_done", bus.done, 1);
    do_arm(3);
    s(1, rnd());
    idle();
    idle();
    chk("G_gap", bus.wr_count, 1);
    s(0, rnd());
    s(0, rnd());
    chk("G_done", bus.done, 1);
    chk("G_cnt", bus.wr_count, 3);
    do_arm(5);
    s(1, rnd());
    step(0, 0, 0, 1, rnd(), 0, 1, 0);
    step(1, 0, 0, 0, rnd(), 0, 0, 0);
    chk("H_busy", bus.busy, 0);
    chk("H_cnt", bus.wr_count, 0);
    chk("H_rvalid", bus.cpu_rvalid, 0);
    chk("H_rdata", bus.cpu_rdata, 0);
    idle();
    chk("H_drop", bus.cpu_rvalid, 0);
    s(1, rnd());
    chk("H_ign", bus.busy, 0);
    chk("H_ign_cnt", bus.wr_count, 0);
    for (int i = 0; i < 400; i++)
      step($urandom % 100 == 0, $urandom % 20 == 0, $urandom % 8 == 0, $urandom % 4 != 0,
           rnd(), 5'($urandom % 18), 1'($urandom), 6'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
